// File: rtl/frog_collide.sv
// frog_collide: per-frame collision / goal referee for the frog game.
//
// Each clock the frog box is compared against N_OBS obstacle boxes and against
// the goal line; the results are registered (hit_q / goal_q, one clock of
// latency). On every qualifying animation strobe (i_ani_stb && i_animate) a
// small state machine acts on those flags: it takes lives, counts goals,
// holds the frog at spawn (o_dead) for HOLD_FRAMES frames, and parks in a
// game-over state until i_restart.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_ani_stb, i_animate    frame strobe and frame-evaluation enable
//   i_restart               leave game-over (sampled on a qualifying strobe)
//   i_frog_{x1,x2,y1,y2}    frog box edges, 12 bit
//   i_obs_{x1,x2,y1,y2}     packed obstacle edges, obstacle k in [12k+11:12k]
//   o_dead                  respawn request to the frog block
//   o_lives, o_score        remaining lives, saturating goal count
//   o_game_over             high while in the game-over state
//   o_event                 one-clock pulse on any death or goal
//
// Optional feature: define FROG_COLLIDE_BOUNDARY_KILL_EN to make the frog die
// when its box wraps or leaves the D_WIDTH x D_HEIGHT display.

// One obstacle lane: strict overlap test. Touching edges do not overlap, and a
// zero-width obstacle (x1 == x2) is a disabled slot that never hits.
module frog_collide_box (
    input  logic [11:0] fx1,
    input  logic [11:0] fx2,
    input  logic [11:0] fy1,
    input  logic [11:0] fy2,
    input  logic [11:0] ox1,
    input  logic [11:0] ox2,
    input  logic [11:0] oy1,
    input  logic [11:0] oy2,
    output logic        hit
);
    always_comb begin
        hit = (ox1 != ox2) &&
              (fx1 < ox2) && (fx2 > ox1) &&
              (fy1 < oy2) && (fy2 > oy1);
    end
endmodule

module frog_collide #(
    parameter int N_OBS       = 4,
    parameter int LIVES       = 3,
    parameter int GOAL_Y      = 40,
    parameter int HOLD_FRAMES = 30,
    parameter int D_WIDTH     = 640,
    parameter int D_HEIGHT    = 480
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ani_stb,
    input  logic                 i_animate,
    input  logic                 i_restart,
    input  logic [11:0]          i_frog_x1,
    input  logic [11:0]          i_frog_x2,
    input  logic [11:0]          i_frog_y1,
    input  logic [11:0]          i_frog_y2,
    input  logic [12*N_OBS-1:0]  i_obs_x1,
    input  logic [12*N_OBS-1:0]  i_obs_x2,
    input  logic [12*N_OBS-1:0]  i_obs_y1,
    input  logic [12*N_OBS-1:0]  i_obs_y2,
    output logic                 o_dead,
    output logic [3:0]           o_lives,
    output logic [7:0]           o_score,
    output logic                 o_game_over,
    output logic                 o_event
);

`ifdef FROG_COLLIDE_BOUNDARY_KILL_EN
    localparam bit BOUNDARY_KILL = 1'b1;
`else
    localparam bit BOUNDARY_KILL = 1'b0;
`endif

    typedef enum logic [1:0] {PLAY, DIE, GOAL, OVER} state_t;

    state_t             state;
    logic [7:0]         hold;
    logic               hit_q;
    logic               goal_q;
    logic [N_OBS-1:0]   obs_hit;
    logic               oob;
    logic               stb;

    // Per-obstacle overlap lanes.
    for (genvar k = 0; k < N_OBS; k++) begin : g_obs
        frog_collide_box u_box (
            .fx1 (i_frog_x1),
            .fx2 (i_frog_x2),
            .fy1 (i_frog_y1),
            .fy2 (i_frog_y2),
            .ox1 (i_obs_x1[12*k +: 12]),
            .ox2 (i_obs_x2[12*k +: 12]),
            .oy1 (i_obs_y1[12*k +: 12]),
            .oy2 (i_obs_y2[12*k +: 12]),
            .hit (obs_hit[k])
        );
    end

    // Off-screen / wrapped frog box. Constant-gated so the default build
    // reduces it to zero.
    always_comb begin
        oob = BOUNDARY_KILL &&
              ((i_frog_x1 > i_frog_x2) ||
               (i_frog_y1 > i_frog_y2) ||
               (i_frog_x2 >= 12'(D_WIDTH)) ||
               (i_frog_y2 >= 12'(D_HEIGHT)));
    end

    assign stb = i_ani_stb && i_animate;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= PLAY;
            hold        <= '0;
            hit_q       <= 1'b0;
            goal_q      <= 1'b0;
            o_dead      <= 1'b0;
            o_lives     <= 4'(LIVES);
            o_score     <= '0;
            o_game_over <= 1'b0;
            o_event     <= 1'b0;
        end else begin
            // Flags track the coordinates every clock, even while frozen.
            hit_q   <= (|obs_hit) || oob;
            goal_q  <= (i_frog_y1 <= 12'(GOAL_Y));
            o_event <= 1'b0;

            if (stb) begin
                case (state)
                    PLAY: begin
                        // Hit has priority over goal on the same frame.
                        if (hit_q) begin
                            if (o_lives != 4'd0) o_lives <= o_lives - 4'd1;
                            o_event <= 1'b1;
                            o_dead  <= 1'b1;
                            hold    <= 8'(HOLD_FRAMES);
                            state   <= DIE;
                        end else if (goal_q) begin
                            if (o_score != 8'hFF) o_score <= o_score + 8'd1;
                            o_event <= 1'b1;
                            o_dead  <= 1'b1;
                            hold    <= 8'(HOLD_FRAMES);
                            state   <= GOAL;
                        end
                    end
                    DIE, GOAL: begin
                        // The strobe that sees hold==1 is the last held frame.
                        if (hold <= 8'd1) begin
                            hold <= '0;
                            if (state == DIE && o_lives == 4'd0) begin
                                o_game_over <= 1'b1;
                                state       <= OVER;
                            end else begin
                                o_dead <= 1'b0;
                                state  <= PLAY;
                            end
                        end else begin
                            hold <= hold - 8'd1;
                        end
                    end
                    OVER: begin
                        if (i_restart) begin
                            o_lives     <= 4'(LIVES);
                            o_score     <= '0;
                            o_dead      <= 1'b0;
                            o_game_over <= 1'b0;
                            state       <= PLAY;
                        end
                    end
                    default: state <= PLAY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frog_collide.sv
module tb_frog_collide;
    localparam int N_OBS = 4;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                i_ani_stb = 1'b0;
    logic                i_animate = 1'b1;
    logic                i_restart = 1'b0;
    logic [11:0]         fx1, fx2, fy1, fy2;
    logic [12*N_OBS-1:0] ox1, ox2, oy1, oy2;
    logic                o_dead, o_game_over, o_event;
    logic [3:0]          o_lives;
    logic [7:0]          o_score;

    int nvec = 0;
    int nmis = 0;

    frog_collide #(.N_OBS(N_OBS)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ani_stb   (i_ani_stb),
        .i_animate   (i_animate),
        .i_restart   (i_restart),
        .i_frog_x1   (fx1),
        .i_frog_x2   (fx2),
        .i_frog_y1   (fy1),
        .i_frog_y2   (fy2),
        .i_obs_x1    (ox1),
        .i_obs_x2    (ox2),
        .i_obs_y1    (oy1),
        .i_obs_y2    (oy2),
        .o_dead      (o_dead),
        .o_lives     (o_lives),
        .o_score     (o_score),
        .o_game_over (o_game_over),
        .o_event     (o_event)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_frog(input int x1, input int x2, input int y1, input int y2);
        fx1 = 12'(x1); fx2 = 12'(x2); fy1 = 12'(y1); fy2 = 12'(y2);
    endtask

    // Obstacle 0 placed, all other slots zero-width (disabled).
    task automatic set_obs0(input int x1, input int x2, input int y1, input int y2);
        ox1 = '0; ox2 = '0; oy1 = '0; oy2 = '0;
        ox1[11:0] = 12'(x1); ox2[11:0] = 12'(x2);
        oy1[11:0] = 12'(y1); oy2[11:0] = 12'(y2);
    endtask

    // One-clock strobe; returns at the falling edge after the strobe edge, so
    // outputs then reflect that strobe. The leading negedge also gives the
    // flag registers a clock to see freshly set coordinates.
    task automatic strobe();
        @(negedge i_clk);
        i_ani_stb = 1'b1;
        @(negedge i_clk);
        i_ani_stb = 1'b0;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) strobe();
    endtask

    // Count strobes until o_dead drops, bounded.
    task automatic run_hold(input string tag);
        int n;
        n = 0;
        while (o_dead && n < 60) begin
            strobe();
            n++;
        end
        chk(tag, n, 30);
    endtask

    initial begin
        set_frog(309, 331, 449, 471);
        set_obs0(0, 0, 0, 0);
        repeat (3) @(negedge i_clk);
        chk("rst_lives", o_lives, 3);
        chk("rst_score", o_score, 0);
        chk("rst_dead", o_dead, 0);
        chk("rst_over", o_game_over, 0);
        chk("rst_event", o_event, 0);
        i_rst = 1'b0;

        // Touching edge: obstacle x1 == frog x2 -> no hit.
        set_obs0(331, 360, 440, 480);
        for (int i = 0; i < 5; i++) begin
            strobe();
            chk("touch_event", o_event, 0);
        end
        chk("touch_lives", o_lives, 3);
        chk("touch_dead", o_dead, 0);

        // Real overlap -> death, 30-strobe hold.
        set_obs0(300, 340, 440, 480);
        strobe();
        chk("hit_event", o_event, 1);
        chk("hit_lives", o_lives, 2);
        chk("hit_dead", o_dead, 1);
        set_obs0(0, 0, 0, 0);
        strobe();
        chk("hit_event_pulse", o_event, 0);
        // one hold strobe already used above
        strobes(28);
        chk("hit_dead_29", o_dead, 1);
        strobe();
        chk("hit_dead_30", o_dead, 0);

        // y1 = 41 is not a goal; y1 = 40 is.
        set_frog(309, 331, 41, 63);
        strobe();
        chk("nogoal_score", o_score, 0);
        chk("nogoal_event", o_event, 0);
        set_frog(309, 331, 40, 62);
        strobe();
        chk("goal_score", o_score, 1);
        chk("goal_event", o_event, 1);
        chk("goal_lives", o_lives, 2);
        run_hold("goal_hold");

        // Freeze while i_animate is low.
        set_frog(309, 331, 449, 471);
        set_obs0(300, 340, 440, 480);
        strobe();
        chk("frz_lives", o_lives, 1);
        set_obs0(0, 0, 0, 0);
        strobes(17);
        i_animate = 1'b0;
        strobes(20);
        chk("frz_dead_frozen", o_dead, 1);
        i_animate = 1'b1;
        strobes(12);
        chk("frz_dead_12", o_dead, 1);
        strobe();
        chk("frz_dead_13", o_dead, 0);

        // Hit and goal on the same frame: hit wins. Third death -> OVER.
        set_frog(309, 331, 40, 62);
        set_obs0(300, 340, 30, 70);
        strobe();
        chk("both_lives", o_lives, 0);
        chk("both_score", o_score, 1);
        chk("both_event", o_event, 1);
        strobes(30);
        chk("over_flag", o_game_over, 1);
        chk("over_lives", o_lives, 0);
        chk("over_dead", o_dead, 1);
        for (int i = 0; i < 3; i++) begin
            strobe();
            chk("over_ignore_event", o_event, 0);
        end
        chk("over_ignore_lives", o_lives, 0);
        i_restart = 1'b1;
        strobe();
        i_restart = 1'b0;
        chk("restart_lives", o_lives, 3);
        chk("restart_score", o_score, 0);
        chk("restart_over", o_game_over, 0);
        chk("restart_dead", o_dead, 0);

        // Score saturation over 256 goals.
        set_obs0(0, 0, 0, 0);
        set_frog(309, 331, 40, 62);
        for (int g = 0; g < 256; g++) begin
            strobe();
            if (g == 254) chk("sat_score_255", o_score, 255);
            strobes(30);
        end
        chk("sat_score_hold", o_score, 255);
        chk("sat_lives", o_lives, 3);

        // Async reset in the middle of a death hold (hold == 12).
        set_frog(309, 331, 449, 471);
        set_obs0(300, 340, 440, 480);
        strobe();
        chk("mid_lives", o_lives, 2);
        set_obs0(0, 0, 0, 0);
        strobes(18);
        chk("mid_dead", o_dead, 1);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_lives", o_lives, 3);
        chk("arst_score", o_score, 0);
        chk("arst_dead", o_dead, 0);
        chk("arst_over", o_game_over, 0);
        chk("arst_event", o_event, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        strobe();
        chk("arst_play", o_dead, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/frog_collide.md
Name: frog_collide

Overview:
- Downstream of the frog sprite block: consumes the frog bounding box plus N obstacle boxes each animation frame.
- Detects collisions and goal arrival, and manages lives, score and game-over.
- Drives the frog's i_dead respawn input (o_dead) and feeds the score/lives display.
- Holds the frog at spawn for a fixed number of frames after each death or goal.

Parameters:
- N_OBS, 4, number of obstacle boxes checked per frame (1..8).
- LIVES, 3, lives at reset/restart (1..15).
- GOAL_Y, 40, goal reached when frog top edge o_y1 <= GOAL_Y.
- HOLD_FRAMES, 30, frames o_dead stays high after a death or goal (1..255).
- D_WIDTH, 640, display width; used only by the optional feature.
- D_HEIGHT, 480, display height; used only by the optional feature.

Ports:
- i_clk  in  1  base clock
- i_rst  in  1  asynchronous active-high reset
- i_ani_stb  in  1  animation strobe, one clk per frame
- i_animate  in  1  frame evaluation enabled when high
- i_restart  in  1  leave OVER state; sampled on qualifying strobe
- i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2  in  12 each  frog box edges
- i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2  in  12*N_OBS each  packed obstacle edges; obstacle k occupies bits [12k+11:12k]
- o_dead  out  1  respawn request to frog block
- o_lives  out  4  remaining lives
- o_score  out  8  goals reached, saturating
- o_game_over  out  1  high in OVER state
- o_event  out  1  one-clk pulse on any death or goal

Behaviour:
- Reset (async, i_rst=1): state PLAY, o_dead=0, o_lives=LIVES, o_score=0, o_game_over=0, o_event=0, hold counter=0, hit_q=0.
- Overlap, per obstacle, unsigned 12-bit compares, strict: fx1<ox2 && fx2>ox1 && fy1<oy2 && fy2>oy1.
  - Edges that only touch do not hit.
  - A zero-width obstacle (ox1==ox2) never hits; this is the disabled-slot encoding.
- hit_q = OR of all overlaps, registered every clk. goal_q = (fy1 <= GOAL_Y), registered every clk. Latency 1 clk from coordinates to flag.
- Qualifying strobe = i_ani_stb && i_animate. All state changes below occur only on a qualifying strobe, except reset.
- PLAY: o_dead=0.
  - If hit_q: o_lives-=1, o_event=1 for 1 clk, hold=HOLD_FRAMES, go DIE.
  - Else if goal_q: o_score+=1 (saturate at 255), o_event=1 for 1 clk, hold=HOLD_FRAMES, go GOAL.
  - Simultaneous hit and goal: hit wins, no score.
- DIE: o_dead=1. Hold decrements each qualifying strobe. On the strobe where hold==1: if o_lives==0, go OVER; else go PLAY.
- GOAL: o_dead=1. Same hold countdown, then go PLAY. Lives unchanged.
- OVER: o_dead=1, o_game_over=1. Hits and goals are ignored. If i_restart: o_lives=LIVES, o_score=0, go PLAY.
- o_lives never underflows; a decrement is only issued from PLAY while o_lives>=1.
- i_animate low: the machine freezes (hold counter and state held); hit_q/goal_q keep updating.
- Reset mid-hold or in OVER returns immediately to reset values.
- Frog edge wrap-around (e.g. x1 near 4095 after underflow) is compared as unsigned; no special handling without the optional feature.

Optional Feature:
- Macro FROG_COLLIDE_BOUNDARY_KILL_EN.
- Defined: an out-of-bounds condition ORs into hit_q. Out of bounds means fx1 > fx2 (wrapped), fy1 > fy2 (wrapped), fx2 >= D_WIDTH, or fy2 >= D_HEIGHT. The frog dies on leaving the screen.
- Undefined: boundary ignored; only obstacle overlap and goal are evaluated.

Test Plan:
- Reset, then frog 309..331/449..471, obstacle0 300..340/440..480, strobe -> o_event pulse, o_lives 3->2, o_dead=1 for exactly 30 strobes, then PLAY with o_dead=0.
- Obstacle0 at x 331..360 (touching frog x2=331), all other slots zero-width, 5 strobes -> no hit, o_lives=3, o_event never high.
- Frog y1=40 with no overlap, strobe -> o_score 0->1, o_dead high 30 strobes, o_lives unchanged; 256 goals -> o_score stays 255.
- Frog y1=40 and overlapping obstacle on the same strobe -> o_lives decrements, o_score unchanged.
- Three deaths with LIVES=3 -> after third hold o_game_over=1, o_lives=0; further hits ignored; i_restart on strobe -> o_lives=3, o_score=0, PLAY.
- Assert i_rst mid-DIE (hold=12) -> all outputs at reset values immediately, asynchronously; i_animate=0 during hold -> hold count frozen.
